trade_dispatcher: RTL
=====================

# trade_dispatcher

Downstream stage of the upstream order processor. Consumes each accumulated order together with the current `accumulated_orders` / `max_to_trade` pair and `thenewmax`, and gates it against the trading limit. Accepted orders go into a FIFO drained by a valid/ready handshake toward the exchange-side sender. Rejected orders raise a reject pulse. A run of limit breaches halts trading until a new maximum arrives.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `REJECT_LIMIT`, 4 — consecutive limit-breach rejects that force HALTED; 1..15.

Ports:
- `clk`  in  1  — single clock for all logic.
- `rst`  in  1  — asynchronous, active-high reset.
- `order_valid`  in  1  — one-cycle strobe; `client_id`, `amount`, `accumulated_orders` and `max_to_trade` are valid with it.
- `client_id`  in  5  — originating client.
- `amount`  in  32  — order amount, unsigned.
- `accumulated_orders`  in  32  — running total including this order, unsigned.
- `max_to_trade`  in  32  — current limit, unsigned.
- `thenewmax`  in  1  — one-cycle strobe: a new limit was loaded upstream.
- `trade_valid`  out  1  — FIFO head valid.
- `trade_ready`  in  1  — consumer accepts head.
- `trade_client_id`  out  5  — head client id.
- `trade_amount`  out  32  — head amount.
- `reject`  out  1  — one-cycle reject pulse.
- `reject_client_id`  out  5  — client of rejected order; held until the next reject.
- `halted`  out  1  — high in HALTED.
- `fifo_count`  out  $clog2(DEPTH)+1  — current occupancy.
- `accepted_cnt`, `rejected_cnt`  out  16 each — present only with `TRADE_DISP_STATS_EN`.

## Operation
- FSM states: ACTIVE (reset state) and HALTED. A 4-bit consecutive-breach counter `breach_run` tracks breaches.
- On `order_valid`, the order is evaluated in strict priority:
  1. State is HALTED → reject.
  2. `accumulated_orders > max_to_trade` (unsigned) → reject as a breach; `breach_run` increments.
  3. FIFO full → reject as an overflow; `breach_run` is unchanged.
  4. Otherwise → accept: push {`client_id`, `amount`} and clear `breach_run`.
- `breach_run` reaching `REJECT_LIMIT` → HALTED on the next cycle.
- `thenewmax` in HALTED → ACTIVE on the next cycle and `breach_run` := 0.
- `thenewmax` in ACTIVE → `breach_run` := 0.
- `order_valid` and `thenewmax` in the same cycle: the order is evaluated against the current state first, then the `thenewmax` effect is applied. In HALTED the order is rejected and `breach_run` ends at 0.
- FIFO is first-word fall-through:
  - `trade_valid = (fifo_count != 0)`.
  - Pop on `trade_valid && trade_ready`.
  - Pointers wrap modulo DEPTH.
  - The full check uses occupancy before any same-cycle pop, so a push to a full FIFO is rejected even while popping.
  - Push and pop in the same non-full, non-empty cycle leave `fifo_count` unchanged.
- `trade_*` outputs are stable while `trade_valid && !trade_ready`.

## Timing
- Reset values:
  - State ACTIVE; `breach_run` 0.
  - `trade_valid` 0, `trade_client_id` 0, `trade_amount` 0.
  - `reject` 0, `reject_client_id` 0, `halted` 0.
  - `fifo_count` 0; stats counters 0.
- Accept latency: an order accepted at cycle N is presented on `trade_*` at cycle N+1 if the FIFO was empty.
- Reject latency: `reject` is high for exactly cycle N+1.
- `halted` rises the cycle after the `REJECT_LIMIT`-th breach's `order_valid`. It falls the cycle after `thenewmax`.
- Reset asserted mid-operation empties the FIFO immediately (asynchronously). Entries in flight are lost; `trade_valid` drops the same instant.

## Configuration
- `TRADE_DISP_STATS_EN` defined:
  - Adds `accepted_cnt` and `rejected_cnt`.
  - They increment one cycle after each accept or reject.
  - They saturate at 16'hFFFF and clear only on `rst`.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then 3 orders (id 1,2,3; amount 10; acc 10,20,30; max 100), `trade_ready`=1 → three trades appear at N+1 each, no `reject`, `fifo_count` returns to 0.
- `trade_ready`=0, DEPTH+1 in-limit orders → first DEPTH accepted, `fifo_count`=DEPTH, last order gives `reject` with its id and `halted` stays 0.
- REJECT_LIMIT=4, four orders with acc 200 / max 100 → four rejects, `halted`=1 one cycle after the 4th. An in-limit order is then rejected. After `thenewmax`, `halted`=0 and the next in-limit order is accepted.
- Three breaches, one accept, three breaches → `halted` never asserts; the breach run was cleared by the accept.
- `thenewmax` coincident with `order_valid` while HALTED → that order is rejected, `halted`=0 next cycle, the following order is accepted.
- With `TRADE_DISP_STATS_EN`: 5 accepts, 2 rejects → `accepted_cnt`=5, `rejected_cnt`=2. Forcing 65,536 rejects holds `rejected_cnt` at 16'hFFFF.

Source files
------------

// File: rtl/trade_dispatcher_if.sv
// Handshake and data bundle between the order processor / exchange sender
// and trade_dispatcher. The master side feeds orders and drains trades; the
// slave side is the dispatcher itself. Statistics signals exist only when
// TRADE_DISP_STATS_EN is defined.
interface trade_dispatcher_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          order_valid;
  logic [4:0]    client_id;
  logic [31:0]   amount;
  logic [31:0]   accumulated_orders;
  logic [31:0]   max_to_trade;
  logic          thenewmax;
  logic          trade_valid;
  logic          trade_ready;
  logic [4:0]    trade_client_id;
  logic [31:0]   trade_amount;
  logic          reject;
  logic [4:0]    reject_client_id;
  logic          halted;
  logic [CW-1:0] fifo_count;
`ifdef TRADE_DISP_STATS_EN
  logic [15:0]   accepted_cnt;
  logic [15:0]   rejected_cnt;
`endif

  modport master (
    output order_valid, client_id, amount, accumulated_orders, max_to_trade,
           thenewmax, trade_ready,
    input  trade_valid, trade_client_id, trade_amount, reject,
           reject_client_id, halted, fifo_count
`ifdef TRADE_DISP_STATS_EN
    , input accepted_cnt, rejected_cnt
`endif
  );

  modport slave (
    input  order_valid, client_id, amount, accumulated_orders, max_to_trade,
           thenewmax, trade_ready,
    output trade_valid, trade_client_id, trade_amount, reject,
           reject_client_id, halted, fifo_count
`ifdef TRADE_DISP_STATS_EN
    , output accepted_cnt, rejected_cnt
`endif
  );
endinterface

// File: rtl/trade_dispatcher.sv
// trade_dispatcher: gates accumulated orders against the trading limit,
// queues accepted orders in a first-word-fall-through FIFO toward the
// exchange sender, pulses reject for refused orders and halts trading after
// REJECT_LIMIT consecutive limit breaches until a new maximum is loaded.
// Optional feature macro: TRADE_DISP_STATS_EN adds saturating accept/reject
// counters (accepted_cnt / rejected_cnt) on the interface.
module trade_dispatcher #(
  parameter int DEPTH        = 8,
  parameter int REJECT_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  trade_dispatcher_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [3:0]    LIMIT_RUN = 4'(REJECT_LIMIT);

  typedef enum logic {
    ACTIVE = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    breach_run, breach_run_nxt;
  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          is_halted, is_breach, is_full;
  logic          push, pop, rej, breach_hit, limit_hit;
  logic          reject_q;
  logic [4:0]    reject_id_q;

  // Order evaluation in priority order: halted, limit breach, FIFO full, accept.
  always_comb begin
    is_halted  = (state == HALTED);
    is_breach  = (bus.accumulated_orders > bus.max_to_trade);
    is_full    = (count == FULL_CNT);
    breach_hit = bus.order_valid && !is_halted && is_breach;
    push       = bus.order_valid && !is_halted && !is_breach && !is_full;
    rej        = bus.order_valid && !push;
    pop        = (count != '0) && bus.trade_ready;
    limit_hit  = breach_hit && ((breach_run + 4'd1) == LIMIT_RUN);
  end

  // Breach run: order effect first, then a new maximum clears it.
  always_comb begin
    breach_run_nxt = breach_run;
    if (breach_hit) begin
      breach_run_nxt = breach_run + 4'd1;
    end else if (push) begin
      breach_run_nxt = 4'd0;
    end
    if (bus.thenewmax) begin
      breach_run_nxt = 4'd0;
    end
  end

  // FSM state and breach-run registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACTIVE;
      breach_run <= 4'd0;
    end else begin
      state      <= state_nxt;
      breach_run <= breach_run_nxt;
    end
  end

  // FSM next state; a coincident new maximum overrides the halting breach.
  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE: if (limit_hit && !bus.thenewmax) state_nxt = HALTED;
      HALTED: if (bus.thenewmax)               state_nxt = ACTIVE;
      default: state_nxt = ACTIVE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.halted = (state == HALTED);
  end

  // FIFO storage; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.client_id, bus.amount};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head presentation: first word falls through, zeroed while empty.
  always_comb begin
    bus.trade_valid = (count != '0);
    bus.fifo_count  = count;
    if (count != '0) begin
      {bus.trade_client_id, bus.trade_amount} = mem[rd_ptr];
    end else begin
      bus.trade_client_id = '0;
      bus.trade_amount    = '0;
    end
  end

  // Reject pulse and sticky id of the most recent rejected order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_q    <= 1'b0;
      reject_id_q <= '0;
    end else begin
      reject_q <= rej;
      if (rej) reject_id_q <= bus.client_id;
    end
  end

  // Reject outputs.
  always_comb begin
    bus.reject           = reject_q;
    bus.reject_client_id = reject_id_q;
  end

`ifdef TRADE_DISP_STATS_EN
  logic [15:0] acc_cnt_q, rej_cnt_q;

  // Saturating accept/reject statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q <= '0;
      rej_cnt_q <= '0;
    end else begin
      if (push && acc_cnt_q != 16'hFFFF) acc_cnt_q <= acc_cnt_q + 16'd1;
      if (rej  && rej_cnt_q != 16'hFFFF) rej_cnt_q <= rej_cnt_q + 16'd1;
    end
  end

  // Statistics outputs.
  always_comb begin
    bus.accepted_cnt = acc_cnt_q;
    bus.rejected_cnt = rej_cnt_q;
  end
`endif

endmodule
